readback_serializer: RTL and testbench

- Downstream stage of the SPI packetizer on the read-back path, in the clk domain.
- On a one-cycle request it waits a fixed memory read latency, then captures the word from the selected memory (act, param or inst).
- It splits that word into SPI-sized bytes, MSB byte first, and pushes them into the write FIFO that feeds MISO.
- It honours FIFO-full backpressure and signals completion.

---
 rtl/readback_serializer.sv | 147 ++++++++++++++
 tb/tb_readback_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/readback_serializer.sv
// rtl/readback_serializer.sv - read-back word capture and MSB-first byte serializer into the MISO write FIFO
module readback_serializer #(
  parameter int         WIDTH_ACT_MEM    = 8,
  parameter int         WIDTH_PARAM_MEM  = 128,
  parameter int         WIDTH_INST_MEM   = 80,
  parameter int         WIDTH_SPI_WORD   = 8,
  parameter int         MEM_RD_LATENCY   = 2,
  parameter logic [1:0] ACT_MEM_HEADER   = 2'b10,
  parameter logic [1:0] PARAM_MEM_HEADER = 2'b01,
  parameter logic [1:0] INST_MEM_HEADER  = 2'b11
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req,
  input  logic [1:0]                 mem_sel,
  input  logic                       abort,
  input  logic [WIDTH_ACT_MEM-1:0]   act_rd_data,
  input  logic [WIDTH_PARAM_MEM-1:0] param_rd_data,
  input  logic [WIDTH_INST_MEM-1:0]  inst_rd_data,
  input  logic                       fifo_full,
  output logic                       fifo_wr,
  output logic [WIDTH_SPI_WORD-1:0]  fifo_data,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  // Bytes per memory word; the shift register is sized for the widest memory.
  localparam int N_ACT   = (WIDTH_ACT_MEM   + WIDTH_SPI_WORD - 1) / WIDTH_SPI_WORD;
  localparam int N_PARAM = (WIDTH_PARAM_MEM + WIDTH_SPI_WORD - 1) / WIDTH_SPI_WORD;
  localparam int N_INST  = (WIDTH_INST_MEM  + WIDTH_SPI_WORD - 1) / WIDTH_SPI_WORD;
  localparam int N_AP    = (N_ACT > N_PARAM) ? N_ACT : N_PARAM;
  localparam int N_MAX   = (N_AP > N_INST) ? N_AP : N_INST;
  localparam int SH_W    = N_MAX * WIDTH_SPI_WORD;
  localparam int CNT_W   = $clog2(N_MAX + 1);
  localparam logic [3:0] LAT_LOAD = 4'((MEM_RD_LATENCY > 0) ? MEM_RD_LATENCY - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [SH_W-1:0]   r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [3:0]        r_lat_cnt, w_lat_cnt_nxt;
  logic [1:0]        r_sel, w_sel_nxt;
  logic              w_sel_valid;

  // Right-align the selected word, zero-pad to whole bytes, then place its top byte at the MSB end.
  function automatic logic [SH_W-1:0] f_align(input logic [1:0]                 sel,
                                               input logic [WIDTH_ACT_MEM-1:0]   act,
                                               input logic [WIDTH_PARAM_MEM-1:0] param,
                                               input logic [WIDTH_INST_MEM-1:0]  inst);
    logic [SH_W-1:0] v;
    v = '0;
    if (sel == ACT_MEM_HEADER)
      v = SH_W'(act) << (SH_W - N_ACT * WIDTH_SPI_WORD);
    else if (sel == PARAM_MEM_HEADER)
      v = SH_W'(param) << (SH_W - N_PARAM * WIDTH_SPI_WORD);
    else if (sel == INST_MEM_HEADER)
      v = SH_W'(inst) << (SH_W - N_INST * WIDTH_SPI_WORD);
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] f_count(input logic [1:0] sel);
    logic [CNT_W-1:0] n;
    n = '0;
    if (sel == ACT_MEM_HEADER)        n = CNT_W'(N_ACT);
    else if (sel == PARAM_MEM_HEADER) n = CNT_W'(N_PARAM);
    else if (sel == INST_MEM_HEADER)  n = CNT_W'(N_INST);
    return n;
  endfunction

  assign w_sel_valid = (mem_sel == ACT_MEM_HEADER) || (mem_sel == PARAM_MEM_HEADER) ||
                       (mem_sel == INST_MEM_HEADER);

  // A push needs the FIFO to have room and is cancelled by an abort in the same cycle.
  assign fifo_wr   = (r_state == S_SEND) && !fifo_full && !abort;
  assign fifo_data = r_shift[SH_W-1 -: WIDTH_SPI_WORD];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign overrun   = req && (r_state != S_IDLE) && !abort;

  // Next-state and datapath update; abort overrides every other transition.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_byte_cnt_nxt = r_byte_cnt;
    w_lat_cnt_nxt  = r_lat_cnt;
    w_sel_nxt      = r_sel;
    case (r_state)
      S_IDLE: begin
        if (req && w_sel_valid) begin
          w_sel_nxt = mem_sel;
          if (MEM_RD_LATENCY == 0) begin
            w_shift_nxt    = f_align(mem_sel, act_rd_data, param_rd_data, inst_rd_data);
            w_byte_cnt_nxt = f_count(mem_sel);
            w_state_nxt    = S_SEND;
          end else begin
            w_lat_cnt_nxt = LAT_LOAD;
            w_state_nxt   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == 4'd0) begin
          w_shift_nxt    = f_align(r_sel, act_rd_data, param_rd_data, inst_rd_data);
          w_byte_cnt_nxt = f_count(r_sel);
          w_state_nxt    = S_SEND;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 4'd1;
        end
      end
      S_SEND: begin
        if (fifo_wr) begin
          w_shift_nxt    = r_shift << WIDTH_SPI_WORD;
          w_byte_cnt_nxt = r_byte_cnt - CNT_W'(1);
          if (r_byte_cnt == CNT_W'(1))
            w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_shift_nxt    = '0;
      w_byte_cnt_nxt = '0;
      w_lat_cnt_nxt  = '0;
    end
  end

  // State and datapath registers; reset discards any stream in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_lat_cnt  <= '0;
      r_sel      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_lat_cnt  <= w_lat_cnt_nxt;
      r_sel      <= w_sel_nxt;
    end
  end

endmodule

// File: tb/tb_readback_serializer.sv
// tb/tb_readback_serializer.sv - directed scoreboard bench for readback_serializer
module tb_readback_serializer;
  localparam int LAT = 2;
  localparam logic [1:0] SEL_ACT   = 2'b10;
  localparam logic [1:0] SEL_PARAM = 2'b01;
  localparam logic [1:0] SEL_INST  = 2'b11;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req;
  logic [1:0]   mem_sel;
  logic         abort;
  logic [7:0]   act_rd_data;
  logic [127:0] param_rd_data;
  logic [79:0]  inst_rd_data;
  logic         fifo_full;
  logic         fifo_wr;
  logic [7:0]   fifo_data;
  logic         busy;
  logic         done;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  logic [7:0] exp_q[$];

  readback_serializer #(.MEM_RD_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .mem_sel(mem_sel), .abort(abort),
    .act_rd_data(act_rd_data), .param_rd_data(param_rd_data), .inst_rd_data(inst_rd_data),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [127:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(data[i*8 +: 8]);
  endtask

  // Request is sampled at the next edge (edge T); returns just after edge T.
  task automatic issue_req(input logic [1:0] sel);
    mem_sel = sel;
    req     = 1'b1;
    tick();
    req     = 1'b0;
    mem_sel = 2'b00;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check(tag, done, 1'b1);
  endtask

  // Scoreboard: every push is popped against the expected byte stream.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && fifo_wr === 1'b1) begin
      n_push++;
      if (exp_q.size() == 0) begin
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_push: observed byte %0h expected no push", fifo_data);
        end
      end else begin
        check("push_byte", fifo_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    reset_n = 1'b0; req = 1'b0; mem_sel = 2'b00; abort = 1'b0; fifo_full = 1'b0;
    act_rd_data = 8'h00; param_rd_data = '0; inst_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_wr", fifo_wr, 1'b0);
    check("rst_fifo_data", fifo_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    tick();

    // Act read: push at edge T+3, done in cycle T+3..T+4.
    act_rd_data = 8'hA5;
    push_bytes(128'hA5, 1);
    issue_req(SEL_ACT);
    check("act_busy_wait", busy, 1'b1);
    check("act_wr_wait0", fifo_wr, 1'b0);
    tick();
    check("act_wr_wait1", fifo_wr, 1'b0);
    tick();
    check("act_wr_send", fifo_wr, 1'b1);
    check("act_data_send", fifo_data, 8'hA5);
    tick();
    check("act_done", done, 1'b1);
    check("act_wr_done", fifo_wr, 1'b0);
    check("act_busy_done", busy, 1'b1);
    tick();
    check("act_done_low", done, 1'b0);
    check("act_busy_low", busy, 1'b0);
    check("act_q_empty", exp_q.size(), 0);

    // Inst read: 10 back-to-back pushes, done right after.
    inst_rd_data = 80'h0102030405060708090A;
    push_bytes(128'h0102030405060708090A, 10);
    p0 = n_push;
    issue_req(SEL_INST);
    repeat (LAT) tick();
    for (int i = 0; i < 10; i++) begin
      check("inst_wr", fifo_wr, 1'b1);
      tick();
    end
    check("inst_done", done, 1'b1);
    check("inst_wr_after", fifo_wr, 1'b0);
    tick();
    check("inst_idle", busy, 1'b0);
    check("inst_count", n_push - p0, 10);

    // Param read with 3 cycles of FIFO full after the 5th push.
    param_rd_data = 128'h101112131415161718191A1B1C1D1E1F;
    push_bytes(128'h101112131415161718191A1B1C1D1E1F, 16);
    p0 = n_push;
    issue_req(SEL_PARAM);
    repeat (LAT) tick();
    for (int i = 0; i < 5; i++) begin
      check("param_wr_pre", fifo_wr, 1'b1);
      tick();
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("param_wr_full", fifo_wr, 1'b0);
      check("param_data_hold", fifo_data, 8'h15);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    for (int i = 0; i < 11; i++) begin
      check("param_wr_post", fifo_wr, 1'b1);
      tick();
    end
    check("param_done", done, 1'b1);
    check("param_count", n_push - p0, 16);
    check("param_q_empty", exp_q.size(), 0);
    tick();

    // Overrun: second request during SEND is dropped, stream unchanged.
    push_bytes(128'h0102030405060708090A, 10);
    p0 = n_push;
    issue_req(SEL_INST);
    repeat (LAT) tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        act_rd_data = 8'h77;
        req = 1'b1;
        mem_sel = SEL_ACT;
        #1;
        check("ovr_pulse", overrun, 1'b1);
      end
      check("ovr_stream_wr", fifo_wr, 1'b1);
      tick();
      if (i == 2) begin
        req = 1'b0;
        mem_sel = 2'b00;
        #1;
        check("ovr_pulse_end", overrun, 1'b0);
      end
    end
    check("ovr_done", done, 1'b1);
    check("ovr_count", n_push - p0, 10);
    tick();

    // Invalid select is ignored without overrun.
    req = 1'b1;
    mem_sel = 2'b00;
    #1;
    check("inv_overrun", overrun, 1'b0);
    tick();
    req = 1'b0;
    check("inv_busy", busy, 1'b0);
    p0 = n_push;
    repeat (4) tick();
    check("inv_busy_later", busy, 1'b0);
    check("inv_no_push", n_push - p0, 0);

    // Abort a param read after 4 pushes, then run a fresh act read.
    push_bytes(128'h101112131415161718191A1B1C1D1E1F, 16);
    issue_req(SEL_PARAM);
    repeat (LAT) tick();
    for (int i = 0; i < 4; i++) begin
      check("abt_wr_pre", fifo_wr, 1'b1);
      tick();
    end
    abort = 1'b1;
    #1;
    check("abt_wr_forced", fifo_wr, 1'b0);
    check("abt_remaining", exp_q.size(), 12);
    exp_q.delete();
    tick();
    abort = 1'b0;
    check("abt_busy", busy, 1'b0);
    check("abt_no_done", done, 1'b0);
    p0 = n_push;
    repeat (5) tick();
    check("abt_no_push", n_push - p0, 0);
    check("abt_no_done_later", done, 1'b0);
    act_rd_data = 8'h3C;
    push_bytes(128'h3C, 1);
    issue_req(SEL_ACT);
    wait_done("abt_new_done", 20);
    tick();
    check("abt_new_idle", busy, 1'b0);
    check("abt_new_q_empty", exp_q.size(), 0);

    // Abort and request in the same idle cycle: abort wins.
    act_rd_data = 8'h99;
    abort = 1'b1;
    req = 1'b1;
    mem_sel = SEL_ACT;
    tick();
    abort = 1'b0;
    req = 1'b0;
    mem_sel = 2'b00;
    check("abtreq_busy", busy, 1'b0);
    p0 = n_push;
    repeat (4) tick();
    check("abtreq_no_push", n_push - p0, 0);

    // Reset during SEND of an inst read: outputs drop at once, nothing stale afterwards.
    push_bytes(128'h0102030405060708090A, 10);
    issue_req(SEL_INST);
    repeat (LAT) tick();
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr", fifo_wr, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_data", fifo_data, 8'h00);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    p0 = n_push;
    repeat (6) tick();
    check("rst_after_no_push", n_push - p0, 0);
    check("rst_after_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
